// File: rtl/adc_frame_buffer_if.sv
// adc_frame_buffer_if: capture/ADC input side and buffered read-out side of the frame buffer
interface adc_frame_buffer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
);
  logic capture, adc_valid, rd_ready, rd_valid, rd_last, frame_ready, busy, overflow;
  logic [DATA_W-1:0] adc_data, rd_data;
  logic [ADDR_W:0] fill_count;
  modport master(
    output capture, adc_valid, adc_data, rd_ready,
    input rd_valid, rd_data, rd_last, frame_ready, busy, overflow, fill_count
  );
  modport slave(
    input capture, adc_valid, adc_data, rd_ready,
    output rd_valid, rd_data, rd_last, frame_ready, busy, overflow, fill_count
  );
endinterface

// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: captures one frame of ADC samples, then streams it out in capture order
module adc_frame_buffer #(
  parameter int DATA_W = 8,
  parameter int FRAME_LEN = 1000,
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic rst,
  adc_frame_buffer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CAPTURE, FULL, DRAIN} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0] FILL_LAST = (ADDR_W + 1)'(FRAME_LEN - 1);
  state_t state, state_next;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_ptr, rd_ptr_next;
  logic [ADDR_W:0] fill_count;
  logic overflow, wr, xfer, last, start;
  assign start = state == IDLE && bus.capture;
  assign wr = state == CAPTURE && bus.adc_valid;
  assign last = state == DRAIN && rd_ptr == LAST;
  assign xfer = state == DRAIN && bus.rd_ready;
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = bus.capture ? CAPTURE : IDLE;
      CAPTURE: state_next = wr && fill_count == FILL_LAST ? FULL : CAPTURE;
      FULL: state_next = DRAIN;
      DRAIN: state_next = xfer && last ? IDLE : DRAIN;
      default: state_next = IDLE;
    endcase
    rd_ptr_next = state == FULL || (xfer && last) ? '0 : xfer ? rd_ptr + 1'b1 : rd_ptr;
  end
  // rd_data is prefetched from the pointer's next value so it is ready on the first DRAIN cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      fill_count <= '0;
      rd_ptr <= '0;
      rd_data <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      rd_ptr <= rd_ptr_next;
      fill_count <= start ? '0 : wr ? fill_count + 1'b1 : fill_count;
      overflow <= start ? 1'b0 : (state == FULL || state == DRAIN) && bus.adc_valid ? 1'b1 : overflow;
      if (state == FULL || xfer) rd_data <= mem[rd_ptr_next];
    end
  always_ff @(posedge clk)
    if (wr) mem[fill_count[ADDR_W-1:0]] <= bus.adc_data;
  assign bus.rd_valid = state == DRAIN;
  assign bus.rd_last = last;
  assign bus.frame_ready = state == FULL;
  assign bus.busy = state != IDLE;
  assign bus.overflow = overflow;
  assign bus.fill_count = fill_count;
  assign bus.rd_data = rd_data;
endmodule

// File: tb/tb_adc_frame_buffer.sv
// tb_adc_frame_buffer: scenario tasks checked against a queue model of the captured frame
module tb_adc_frame_buffer;
  localparam int DW = 8, FL = 8, AW = 3;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  adc_frame_buffer_if #(.DATA_W(DW), .ADDR_W(AW)) b();
  adc_frame_buffer #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(b));
  int vectors = 0, errors = 0;
  logic [DW-1:0] exp_q[$];

  // stimulus only: capture pulse, then FL samples with gap idle cycles; returns in the FULL cycle
  task automatic load(input int gap, input bit rnd);
    logic [DW-1:0] d;
    exp_q.delete();
    b.capture = 1; @(negedge clk); b.capture = 0;
    for (int i = 0; i < FL; i++) begin
      d = rnd ? DW'($urandom) : DW'(10 * (i + 1));
      b.adc_valid = 1; b.adc_data = d; exp_q.push_back(d);
      @(negedge clk);
      b.adc_valid = 0;
      if (i < FL - 1) repeat (gap) @(negedge clk);
    end
  endtask

  task automatic flush();
    b.rd_ready = 1;
    for (int c = 0; c < 40 && b.busy; c++) @(negedge clk);
    b.rd_ready = 0;
  endtask

  task automatic test_reset();
    b.capture = 0; b.adc_valid = 0; b.adc_data = 0; b.rd_ready = 0; rst = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({b.busy, b.rd_valid, b.rd_last, b.frame_ready, b.overflow, b.fill_count, b.rd_data} !== 17'h0) begin
      errors++; $display("FAIL reset_values: got %h want 0", {b.busy, b.rd_valid, b.rd_last, b.frame_ready, b.overflow, b.fill_count, b.rd_data});
    end
    rst = 1; b.adc_valid = 1; b.adc_data = DW'($urandom);
    repeat (3) @(negedge clk);
    b.adc_valid = 0;
    vectors++;
    if ({b.busy, b.overflow, b.fill_count} !== 6'h0) begin
      errors++; $display("FAIL idle_adc_ignored: got busy,ovf,fill=%h want 0", {b.busy, b.overflow, b.fill_count});
    end
  endtask

  task automatic test_fill();
    exp_q.delete();
    b.capture = 1; b.adc_valid = 1; b.adc_data = 8'h55; @(negedge clk);
    b.capture = 0;
    vectors++;
    if ({b.busy, b.fill_count} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL fill_start: got busy,fill=%h want 10", {b.busy, b.fill_count});
    end
    for (int i = 0; i < FL; i++) begin
      b.adc_valid = 1; b.adc_data = DW'(10 * (i + 1)); exp_q.push_back(DW'(10 * (i + 1)));
      @(negedge clk);
      vectors++;
      if ({b.busy, b.frame_ready, b.fill_count} !== {1'b1, i == FL - 1, 4'(i + 1)}) begin
        errors++; $display("FAIL fill_step%0d: got busy,fr,fill=%h want %h", i, {b.busy, b.frame_ready, b.fill_count}, {1'b1, i == FL - 1, 4'(i + 1)});
      end
    end
    b.adc_valid = 0;
  endtask

  // entered in the FULL cycle; drains with rd_ready held high
  task automatic test_stream();
    int idx = 0;
    @(negedge clk);
    for (int c = 0; c < 40 && idx < FL; c++) begin
      vectors++;
      if ({b.rd_valid, b.rd_last, b.rd_data, b.busy} !== {1'b1, idx == FL - 1, exp_q[idx], 1'b1}) begin
        errors++; $display("FAIL stream_word%0d: got v,l,d,busy=%h want %h", idx, {b.rd_valid, b.rd_last, b.rd_data, b.busy}, {1'b1, idx == FL - 1, exp_q[idx], 1'b1});
      end
      b.rd_ready = 1; idx++;
      @(negedge clk);
    end
    b.rd_ready = 0;
    vectors++;
    if ({idx == FL, b.rd_valid, b.busy, b.rd_last} !== 4'b1000) begin
      errors++; $display("FAIL stream_end: got done,v,busy,last=%b want 1000", {idx == FL, b.rd_valid, b.busy, b.rd_last});
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    load(0, 0);
    @(negedge clk);
    for (int c = 0; c < 60 && idx < FL; c++) begin
      vectors++;
      if ({b.rd_valid, b.rd_last, b.rd_data} !== {1'b1, idx == FL - 1, exp_q[idx]}) begin
        errors++; $display("FAIL bp_word%0d_cyc%0d: got v,l,d=%h want %h", idx, c, {b.rd_valid, b.rd_last, b.rd_data}, {1'b1, idx == FL - 1, exp_q[idx]});
      end
      b.rd_ready = c % 3 == 0;
      if (c % 3 == 0) idx++;
      @(negedge clk);
    end
    b.rd_ready = 0;
    vectors++;
    if ({idx == FL, b.rd_valid, b.busy} !== 3'b100) begin
      errors++; $display("FAIL bp_end: got done,v,busy=%b want 100", {idx == FL, b.rd_valid, b.busy});
    end
  endtask

  task automatic test_overflow();
    int idx = 0;
    load(0, 0);
    b.adc_valid = 1; b.adc_data = 8'hFF;
    @(negedge clk);
    for (int c = 0; c < 40 && idx < FL; c++) begin
      vectors++;
      if ({b.rd_valid, b.rd_last, b.rd_data, b.overflow} !== {1'b1, idx == FL - 1, exp_q[idx], 1'b1}) begin
        errors++; $display("FAIL ovf_word%0d: got v,l,d,ovf=%h want %h", idx, {b.rd_valid, b.rd_last, b.rd_data, b.overflow}, {1'b1, idx == FL - 1, exp_q[idx], 1'b1});
      end
      b.rd_ready = 1; idx++;
      @(negedge clk);
    end
    b.rd_ready = 0; b.adc_valid = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({idx == FL, b.busy, b.overflow} !== 3'b101) begin
      errors++; $display("FAIL ovf_sticky: got done,busy,ovf=%b want 101", {idx == FL, b.busy, b.overflow});
    end
    load(0, 1);
    vectors++;
    if ({b.frame_ready, b.overflow} !== 2'b10) begin
      errors++; $display("FAIL ovf_clear: got fr,ovf=%b want 10", {b.frame_ready, b.overflow});
    end
    flush();
  endtask

  // samples every third cycle; capture re-pulsed in the gaps must be ignored
  task automatic test_gapped();
    logic [DW-1:0] d;
    exp_q.delete();
    b.capture = 1; @(negedge clk); b.capture = 0;
    for (int i = 0; i < FL; i++) begin
      d = DW'($urandom);
      b.adc_valid = 1; b.adc_data = d; exp_q.push_back(d);
      @(negedge clk);
      b.adc_valid = 0;
      vectors++;
      if ({b.frame_ready, b.fill_count} !== {i == FL - 1, 4'(i + 1)}) begin
        errors++; $display("FAIL gap_write%0d: got fr,fill=%h want %h", i, {b.frame_ready, b.fill_count}, {i == FL - 1, 4'(i + 1)});
      end
      if (i < FL - 1) begin
        b.capture = 1; b.adc_data = DW'($urandom);
        repeat (2) @(negedge clk);
        b.capture = 0;
        vectors++;
        if ({b.busy, b.frame_ready, b.fill_count} !== {1'b1, 1'b0, 4'(i + 1)}) begin
          errors++; $display("FAIL gap_idle%0d: got busy,fr,fill=%h want %h", i, {b.busy, b.frame_ready, b.fill_count}, {1'b1, 1'b0, 4'(i + 1)});
        end
      end
    end
  endtask

  // leaves the DUT in the FULL cycle of a fresh frame for test_stream
  task automatic test_reset_abort();
    exp_q.delete();
    b.capture = 1; @(negedge clk); b.capture = 0;
    for (int i = 0; i < 5; i++) begin
      b.adc_valid = 1; b.adc_data = DW'(i + 1); @(negedge clk);
    end
    b.adc_valid = 0; rst = 0;
    #1;
    vectors++;
    if ({b.busy, b.rd_valid, b.rd_last, b.frame_ready, b.overflow, b.fill_count, b.rd_data} !== 17'h0) begin
      errors++; $display("FAIL abort_capture: got %h want 0", {b.busy, b.rd_valid, b.rd_last, b.frame_ready, b.overflow, b.fill_count, b.rd_data});
    end
    @(negedge clk); rst = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if ({b.busy, b.frame_ready} !== 2'b00) begin
        errors++; $display("FAIL abort_no_frame%0d: got busy,fr=%b want 00", c, {b.busy, b.frame_ready});
      end
    end
    load(0, 1);
    vectors++;
    if ({b.frame_ready, b.fill_count} !== {1'b1, 4'd8}) begin
      errors++; $display("FAIL abort_refill: got fr,fill=%h want 18", {b.frame_ready, b.fill_count});
    end
  endtask

  task automatic test_drain_abort();
    load(0, 1);
    b.rd_ready = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    vectors++;
    if ({b.busy, b.rd_valid, b.rd_last, b.frame_ready, b.overflow, b.fill_count, b.rd_data} !== 17'h0) begin
      errors++; $display("FAIL abort_drain: got %h want 0", {b.busy, b.rd_valid, b.rd_last, b.frame_ready, b.overflow, b.fill_count, b.rd_data});
    end
    @(negedge clk); rst = 1; b.rd_ready = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({b.busy, b.rd_valid, b.frame_ready} !== 3'b000) begin
      errors++; $display("FAIL abort_drain_idle: got busy,v,fr=%b want 000", {b.busy, b.rd_valid, b.frame_ready});
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    int n, idx;
    bit v, r, drops;
    for (int f = 0; f < 6; f++) begin
      exp_q.delete(); drops = 0; n = 0; idx = 0;
      b.capture = 1; b.adc_valid = 1; b.adc_data = DW'($urandom); @(negedge clk);
      b.capture = 0; b.adc_valid = 0;
      vectors++;
      if ({b.busy, b.overflow, b.fill_count} !== {1'b1, 1'b0, 4'd0}) begin
        errors++; $display("FAIL rnd%0d_start: got busy,ovf,fill=%h want 20", f, {b.busy, b.overflow, b.fill_count});
      end
      for (int c = 0; c < 200 && n < FL; c++) begin
        v = 1'($urandom_range(0, 1)); d = DW'($urandom);
        b.adc_valid = v; b.adc_data = d; b.capture = 1'($urandom_range(0, 1));
        if (v) begin exp_q.push_back(d); n++; end
        @(negedge clk);
        vectors++;
        if ({b.frame_ready, b.fill_count} !== {n == FL, 4'(n)}) begin
          errors++; $display("FAIL rnd%0d_fill: got fr,fill=%h want %h", f, {b.frame_ready, b.fill_count}, {n == FL, 4'(n)});
        end
      end
      v = 1'($urandom_range(0, 1));
      b.adc_valid = v; b.adc_data = DW'($urandom); b.capture = 0; drops |= v;
      @(negedge clk);
      for (int c = 0; c < 200 && idx < FL; c++) begin
        vectors++;
        if ({b.rd_valid, b.rd_last, b.rd_data, b.overflow} !== {1'b1, idx == FL - 1, exp_q[idx], drops}) begin
          errors++; $display("FAIL rnd%0d_word%0d: got v,l,d,ovf=%h want %h", f, idx, {b.rd_valid, b.rd_last, b.rd_data, b.overflow}, {1'b1, idx == FL - 1, exp_q[idx], drops});
        end
        r = 1'($urandom_range(0, 1)); v = 1'($urandom_range(0, 1));
        b.rd_ready = r; b.adc_valid = v; b.adc_data = DW'($urandom); b.capture = 1'($urandom_range(0, 1));
        drops |= v;
        if (r) idx++;
        @(negedge clk);
      end
      b.rd_ready = 0; b.adc_valid = 0; b.capture = 0;
      vectors++;
      if ({idx == FL, b.rd_valid, b.busy, b.overflow} !== {1'b1, 1'b0, 1'b0, drops}) begin
        errors++; $display("FAIL rnd%0d_end: got done,v,busy,ovf=%b want %b", f, {idx == FL, b.rd_valid, b.busy, b.overflow}, {1'b1, 1'b0, 1'b0, drops});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_backpressure();
    test_overflow();
    test_gapped();
    test_stream();
    test_reset_abort();
    test_stream();
    test_drain_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
